// File: rtl/sync7_pkg.sv
// Shared definitions for the 7-bit synchronous serial path (transmitter and receiver).
package sync7_pkg;

  localparam int SYNC7_DATA_W = 7;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } sync7_state_e;

  // Bit-timer width for a given clocks-per-bit divider.
  function automatic int sync7_timer_w(input int baud_div);
    return $clog2(baud_div + 1);
  endfunction

endpackage

// File: rtl/sync7_bit_timer.sv
// Clocks-per-bit counter: counts 0..BAUD_DIV-1 and wraps; wrap flags the last cycle of a bit.
module sync7_bit_timer
  import sync7_pkg::*;
#(
  parameter int BAUD_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic wrap
);

  localparam int TW = sync7_timer_w(BAUD_DIV);
  localparam logic [TW-1:0] LAST = TW'(BAUD_DIV - 1);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  // NOTE: assign a default first so every path of always_comb drives cnt_d (no latch).
  always_comb begin
    cnt_d = cnt_q + TW'(1);
    if (clr || (cnt_q == LAST)) cnt_d = '0;
  end

  assign wrap = !clr && (cnt_q == LAST);

  // NOTE: sequential state uses <= so every register samples the pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sync7_serial_tx.sv
// 7-bit synchronous serial transmitter: start, DATA_W bits LSB first, optional parity, stop.
// Define SYNC7_TX_PARITY_EN to insert an even-parity bit between data and stop.
module sync7_serial_tx
  import sync7_pkg::*;
#(
  parameter int DATA_W    = SYNC7_DATA_W,
  parameter int BAUD_DIV  = 4,
  parameter int STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] i,
  output logic              ready,
  output logic              busy,
  output logic              tx,
  output logic              done
);

  localparam int CNT_MAX = (DATA_W > STOP_BITS) ? DATA_W : STOP_BITS;
  localparam int BW      = $clog2(CNT_MAX + 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_W - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  sync7_state_e      state_q;
  logic [DATA_W-1:0] shreg_q;
  logic [BW-1:0]     bit_cnt_q;
  logic              tx_q;
  logic              ready_q;
  logic              busy_q;
  logic              done_q;
  logic              wrap;
`ifdef SYNC7_TX_PARITY_EN
  logic              parity_q;
`endif

  sync7_bit_timer #(.BAUD_DIV(BAUD_DIV)) u_bit_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_q == IDLE),
    .wrap (wrap)
  );

  // Outputs are registered from the current state, so the line trails the FSM by one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      // NOTE: the shift register is ordinary flops, not a RAM, so it takes the reset too.
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef SYNC7_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      busy_q <= (state_q != IDLE);

      case (state_q)
        START:   tx_q <= 1'b0;
        DATA:    tx_q <= shreg_q[0];
`ifdef SYNC7_TX_PARITY_EN
        PARITY:  tx_q <= parity_q;
`endif
        default: tx_q <= 1'b1;
      endcase

      case (state_q)
        IDLE: begin
          if (en && ready_q) begin
            shreg_q   <= i;
`ifdef SYNC7_TX_PARITY_EN
            parity_q  <= ^i;
`endif
            bit_cnt_q <= '0;
            ready_q   <= 1'b0;
            state_q   <= START;
          end
        end
        START: begin
          if (wrap) state_q <= DATA;
        end
        DATA: begin
          if (wrap) begin
            shreg_q <= shreg_q >> 1;
            if (bit_cnt_q == LAST_DATA) begin
              bit_cnt_q <= '0;
`ifdef SYNC7_TX_PARITY_EN
              state_q   <= PARITY;
`else
              state_q   <= STOP;
`endif
            end else begin
              bit_cnt_q <= bit_cnt_q + BW'(1);
            end
          end
        end
`ifdef SYNC7_TX_PARITY_EN
        PARITY: begin
          if (wrap) state_q <= STOP;
        end
`endif
        STOP: begin
          if (wrap) begin
            if (bit_cnt_q == LAST_STOP) begin
              bit_cnt_q <= '0;
              ready_q   <= 1'b1;
              done_q    <= 1'b1;
              state_q   <= IDLE;
            end else begin
              bit_cnt_q <= bit_cnt_q + BW'(1);
            end
          end
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign tx    = tx_q;
  assign done  = done_q;

endmodule

// File: tb/tb_sync7_serial_tx.sv
// Directed bench for sync7_serial_tx (DATA_W=7, BAUD_DIV=4, STOP_BITS=1); frames hand-encoded.
module tb_sync7_serial_tx;

  localparam int BAUD = 4;
`ifdef SYNC7_TX_PARITY_EN
  localparam int NB = 10;
  // {stop, parity, data[6:0], start}, transmitted from bit 0 upward
  localparam logic [15:0] F_53 = 16'b000000_1_0_1010011_0;
  localparam logic [15:0] F_01 = 16'b000000_1_1_0000001_0;
  localparam logic [15:0] F_02 = 16'b000000_1_1_0000010_0;
`else
  localparam int NB = 9;
  // {stop, data[6:0], start}, transmitted from bit 0 upward
  localparam logic [15:0] F_53 = 16'b0000000_1_1010011_0;
  localparam logic [15:0] F_01 = 16'b0000000_1_0000001_0;
  localparam logic [15:0] F_02 = 16'b0000000_1_0000010_0;
`endif
  localparam int LEN = NB * BAUD;

  logic       clk;
  logic       rst;
  logic       en;
  logic [6:0] i;
  logic       ready;
  logic       busy;
  logic       tx;
  logic       done;

  int checks = 0;
  int errors = 0;

  sync7_serial_tx #(.DATA_W(7), .BAUD_DIV(BAUD), .STOP_BITS(1)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .i     (i),
    .ready (ready),
    .busy  (busy),
    .tx    (tx),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Each frame bit repeated BAUD times; cycle 1 of the frame lands in bit 0.
  function automatic logic [63:0] expand(input logic [15:0] bits);
    logic [63:0] v;
    v = '0;
    for (int b = 0; b < NB; b++)
      for (int k = 0; k < BAUD; k++) v[b*BAUD + k] = bits[b];
    return v;
  endfunction

  task automatic idle_check(input string tag, input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      check({tag, "_tx"},    64'(tx),    64'd1);
      check({tag, "_busy"},  64'(busy),  64'd0);
      check({tag, "_ready"}, 64'(ready), 64'd1);
      check({tag, "_done"},  64'(done),  64'd0);
    end
  endtask

  // Called right after the accepting posedge; samples the idle gap cycle then LEN frame cycles.
  task automatic capture(input string tag, input logic [15:0] fbits, input bit hold,
                         input int inj, input logic [6:0] next_i);
    logic [63:0] obs;
    int busy_n;
    int done_n;
    bit done_last;
    obs = '0; busy_n = 0; done_n = 0; done_last = 1'b0;
    @(negedge clk);
    check({tag, "_gap_tx"},    64'(tx),    64'd1);
    check({tag, "_gap_busy"},  64'(busy),  64'd0);
    check({tag, "_gap_ready"}, 64'(ready), 64'd0);
    if (!hold) en = 1'b0;
    i = next_i;
    for (int c = 1; c <= LEN; c++) begin
      @(negedge clk);
      obs[c-1] = tx;
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (c == LEN) done_last = 1'b1;
      end
      if (inj != 0 && c == inj) begin
        en = 1'b1;
        i  = 7'h7F;
      end
      if (inj != 0 && c == inj + 1) en = 1'b0;
    end
    check({tag, "_frame"},     obs, expand(fbits));
    check({tag, "_busy_cyc"},  64'(busy_n), 64'(LEN));
    check({tag, "_done_cnt"},  64'(done_n), 64'd1);
    check({tag, "_done_last"}, 64'(done_last), 64'd1);
    check({tag, "_ready_end"}, 64'(ready), 64'd1);
  endtask

  initial begin
    rst = 1'b0;
    en  = 1'b1;
    i   = 7'h00;

    // Reset held with en high: line idle, nothing accepted.
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("rst_tx",    64'(tx),    64'd1);
      check("rst_ready", 64'(ready), 64'd1);
      check("rst_busy",  64'(busy),  64'd0);
      check("rst_done",  64'(done),  64'd0);
    end
    en  = 1'b0;
    rst = 1'b1;
    idle_check("post_rst", 2);

    // Single frame.
    @(negedge clk); en = 1'b1; i = 7'b1010011;
    @(posedge clk);
    capture("f53", F_53, 1'b0, 0, 7'b1010011);
    idle_check("f53_after", 2);

    // Parity bit 1 under the parity build; plain frame otherwise.
    @(negedge clk); en = 1'b1; i = 7'h01;
    @(posedge clk);
    capture("f01", F_01, 1'b0, 0, 7'h00);
    idle_check("f01_after", 1);

    // en pulse with 7'h7F mid-frame is dropped; i also changes mid-frame.
    @(negedge clk); en = 1'b1; i = 7'b1010011;
    @(posedge clk);
    capture("drop", F_53, 1'b0, 10, 7'h3C);
    idle_check("drop_after", 3);

    // Back-to-back with en held: second frame after exactly one idle-high cycle.
    @(negedge clk); en = 1'b1; i = 7'h01;
    @(posedge clk);
    capture("b2b_1", F_01, 1'b1, 0, 7'h02);
    @(posedge clk);
    capture("b2b_2", F_02, 1'b0, 0, 7'h00);
    idle_check("b2b_after", 2);

    // Reset during data bit 3 of 7'h55 (bit 3 = 0): line forced high at once.
    @(negedge clk); en = 1'b1; i = 7'h55;
    @(posedge clk);
    @(negedge clk); en = 1'b0;
    for (int c = 0; c < 18; c++) @(negedge clk);
    check("pre_rst_tx",   64'(tx),   64'd0);
    check("pre_rst_busy", 64'(busy), 64'd1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_tx",    64'(tx),    64'd1);
    check("mid_rst_busy",  64'(busy),  64'd0);
    check("mid_rst_ready", 64'(ready), 64'd1);
    check("mid_rst_done",  64'(done),  64'd0);
    for (int c = 0; c < 2; c++) @(negedge clk);
    rst = 1'b1;
    idle_check("no_resume", 6);

    @(negedge clk); en = 1'b1; i = 7'b1010011;
    @(posedge clk);
    capture("after_rst", F_53, 1'b0, 0, 7'h00);
    idle_check("final", 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
